epp_fb_writer: RTL and testbench

EPP_FB_WRITER -- requirements
Module: epp_fb_writer

---
 rtl/epp_fb_writer_pkg.sv | 37 +++
 rtl/epp_fb_writer_if.sv | 28 ++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/epp_fb_writer.sv | 144 ++++++++++++++
 tb/tb_epp_fb_writer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/epp_fb_writer_pkg.sv
// Shared definitions for the EPP framebuffer writer.
//   - Register-map addresses seen through the EPP register port.
//   - STATUS byte bit positions and a helper that assembles the byte.
//   - Framebuffer address width and the queued write entry type.
package epp_fb_writer_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;

    localparam logic [2:0] REG_X_LO   = 3'd0;
    localparam logic [2:0] REG_X_HI   = 3'd1;
    localparam logic [2:0] REG_Y      = 3'd2;
    localparam logic [2:0] REG_PIXEL  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_RANGE_ERR = 7;
    localparam int ST_OVERFLOW  = 6;
    localparam int ST_COUNT_LSB = 0;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } fb_entry_t;

    function automatic logic [7:0] status_byte(input logic       range_err,
                                               input logic       overflow,
                                               input logic [3:0] count);
        logic [7:0] s;
        s                            = 8'h00;
        s[ST_RANGE_ERR]              = range_err;
        s[ST_OVERFLOW]               = overflow;
        s[ST_COUNT_LSB+3:ST_COUNT_LSB] = count;
        return s;
    endfunction

endpackage

// File: rtl/epp_fb_writer_if.sv
// Bus bundle between the EPP register stage and the framebuffer writer.
//   master : EPP stage / graphics-card side (drives register strobes, reg_din, fb_ready)
//   slave  : epp_fb_writer (drives reg_dout, busy, fb_we, fb_addr, fb_data)
interface epp_fb_writer_if;
    import epp_fb_writer_pkg::*;

    logic                 reg_addr_wr;
    logic                 reg_data_wr;
    logic                 reg_data_rd;
    logic [7:0]           reg_din;
    logic [7:0]           reg_dout;
    logic                 busy;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_data;
    logic                 fb_ready;

    modport master (
        output reg_addr_wr, reg_data_wr, reg_data_rd, reg_din, fb_ready,
        input  reg_dout, busy, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  reg_addr_wr, reg_data_wr, reg_data_rd, reg_din, fb_ready,
        output reg_dout, busy, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for pending framebuffer writes.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (pointers/count only)
//   push, din    : enqueue din when not full
//   pop          : dequeue head when not empty
//   dout         : current head entry (valid while !empty)
//   full, empty  : occupancy flags derived from count
//   count        : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      din,
    input  logic                   pop,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_r <= count_r + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only; stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/epp_fb_writer.sv
// EPP framebuffer writer: turns EPP register accesses into queued
// framebuffer pixel writes.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : epp_fb_writer_if.slave -- register strobes/bytes from the EPP
//            stage, reg_dout/busy back to it, fb_we/fb_addr/fb_data/fb_ready
//            handshake to the graphics-card framebuffer.
// Register map: 0 X_LO, 1 X_HI (bit0), 2 Y, 3 PIXEL (write), 4 STATUS (read),
// 5-7 reserved (writes ignored, read 0x00).
// Build option: define EPP_FB_AUTOINC_EN to advance x/y after every accepted
// PIXEL write (raster order with wrap); otherwise x/y move only by register
// writes.
module epp_fb_writer
    import epp_fb_writer_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    epp_fb_writer_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       addr_reg;
    logic [X_W-1:0]   x, x_nxt;
    logic [Y_W-1:0]   y, y_nxt;
    logic             range_err;
    logic             overflow;
    logic [7:0]       reg_dout_r;
    logic [7:0]       rd_data;
    logic             busy_r;

    logic             data_wr;
    logic             pix_wr;
    logic             in_range;
    logic             push;
    logic             pop;
    logic             status_rd;
    logic             range_set;
    logic             ovf_set;
    fb_entry_t        push_entry;
    fb_entry_t        head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] cnt_nxt;

    // An address strobe wins over a coincident data strobe.
    assign data_wr   = bus.reg_data_wr && !bus.reg_addr_wr;
    assign pix_wr    = data_wr && (addr_reg == REG_PIXEL);
    assign in_range  = (int'(x) < H_RES) && (int'(y) < V_RES);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push      = pix_wr && in_range && !fifo_full;
    assign pop       = !fifo_empty && bus.fb_ready;
    assign range_set = pix_wr && !in_range;
    assign ovf_set   = pix_wr && fifo_full;
    assign status_rd = bus.reg_data_rd && (addr_reg == REG_STATUS);
    assign cnt_nxt   = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign push_entry.addr = FB_ADDR_W'(y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(x);
    assign push_entry.data = bus.reg_din;

    pixel_fifo #(
        .DATA_W ($bits(fb_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (data_wr) begin
            case (addr_reg)
                REG_X_LO: x_nxt[7:0] = bus.reg_din;
                REG_X_HI: x_nxt[8]   = bus.reg_din[0];
                REG_Y:    y_nxt      = bus.reg_din;
                default:  ;
            endcase
        end
`ifdef EPP_FB_AUTOINC_EN
        if (push) begin
            if (int'(x) == H_RES - 1) begin
                x_nxt = '0;
                if (int'(y) == V_RES - 1) y_nxt = '0;
                else                      y_nxt = y + Y_W'(1);
            end else begin
                x_nxt = x + X_W'(1);
            end
        end
`endif
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_reg)
            REG_X_LO:   rd_data = x[7:0];
            REG_X_HI:   rd_data = {7'b0, x[8]};
            REG_Y:      rd_data = y;
            REG_STATUS: rd_data = status_byte(range_err, overflow, 4'(fifo_count));
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            x          <= '0;
            y          <= '0;
            range_err  <= 1'b0;
            overflow   <= 1'b0;
            reg_dout_r <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            if (bus.reg_addr_wr) addr_reg <= bus.reg_din[2:0];
            x <= x_nxt;
            y <= y_nxt;
            // A new event in the read cycle outranks the read-to-clear.
            range_err <= range_set | (range_err & ~status_rd);
            overflow  <= ovf_set   | (overflow  & ~status_rd);
            if (bus.reg_data_rd) reg_dout_r <= rd_data;
            busy_r <= (cnt_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.reg_dout = reg_dout_r;
    assign bus.busy     = busy_r;
    assign bus.fb_we    = !fifo_empty;
    assign bus.fb_addr  = head_entry.addr;
    assign bus.fb_data  = head_entry.data;

endmodule

// File: tb/tb_epp_fb_writer.sv
// Self-checking bench for epp_fb_writer: directed register sequences with a
// scoreboard queue of expected framebuffer writes, checked as they retire.
module tb_epp_fb_writer;
    import epp_fb_writer_pkg::*;

`ifdef EPP_FB_AUTOINC_EN
    localparam int AI = 1;
`else
    localparam int AI = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    epp_fb_writer_if bus();

    epp_fb_writer #(
        .H_RES      (320),
        .V_RES      (240),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [24:0] sbq[$];
    logic [24:0] mon_exp;
    logic [7:0]  rd;
    int          mx = 0;
    int          my = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] addr_of(input int xv, input int yv);
        return 17'(yv * 320 + xv);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [2:0] a);
        bus.reg_addr_wr = 1'b1;
        bus.reg_din     = {5'b0, a};
        cycle();
        bus.reg_addr_wr = 1'b0;
    endtask

    task automatic wr_data(input logic [7:0] d);
        bus.reg_data_wr = 1'b1;
        bus.reg_din     = d;
        cycle();
        bus.reg_data_wr = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        set_addr(a);
        wr_data(d);
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        set_addr(a);
        bus.reg_data_rd = 1'b1;
        cycle();
        bus.reg_data_rd = 1'b0;
        d = bus.reg_dout;
    endtask

    task automatic set_xy(input int xv, input int yv);
        logic [8:0] xb;
        logic [7:0] yb;
        xb = 9'(xv);
        yb = 8'(yv);
        reg_write(REG_X_LO, xb[7:0]);
        reg_write(REG_X_HI, {7'b0, xb[8]});
        reg_write(REG_Y, yb);
        mx = xv;
        my = yv;
    endtask

    // PIXEL data write (address register must already point at PIXEL).
    task automatic pix(input logic [7:0] d);
        if (mx < 320 && my < 240 && sbq.size() < 4) begin
            sbq.push_back({addr_of(mx, my), d});
            if (AI == 1) begin
                if (mx == 319) begin
                    mx = 0;
                    my = (my == 239) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
        wr_data(d);
    endtask

    task automatic drain(input string tag);
        bus.fb_ready = 1'b1;
        repeat (8) cycle();
        bus.fb_ready = 1'b0;
        chk({tag, "_fb_we_idle"}, bus.fb_we, 1'b0);
        chk({tag, "_busy_idle"}, bus.busy, 1'b0);
        chk({tag, "_sb_left"}, sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.fb_we === 1'b1 && bus.fb_ready === 1'b1) begin
            mon_exp = (sbq.size() != 0) ? sbq.pop_front() : 'x;
            chk("fb_write", {7'b0, bus.fb_addr, bus.fb_data}, {7'b0, mon_exp});
        end
    end

    initial begin
        bus.reg_addr_wr = 1'b0;
        bus.reg_data_wr = 1'b0;
        bus.reg_data_rd = 1'b0;
        bus.reg_din     = 8'h00;
        bus.fb_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg_dout", bus.reg_dout, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_fb_we", bus.fb_we, 1'b0);
        reset = 1'b0;
        cycle();
        reg_read(REG_STATUS, rd);
        chk("rst_status", rd, 8'h00);

        // Single pixel at (5,2)
        set_xy(5, 2);
        set_addr(REG_PIXEL);
        pix(8'hE3);
        chk("px_fb_we", bus.fb_we, 1'b1);
        chk("px_fb_addr", bus.fb_addr, 17'd645);
        chk("px_fb_data", bus.fb_data, 8'hE3);
        cycle();
        chk("px_hold_addr", bus.fb_addr, 17'd645);
        drain("px");
        reg_read(REG_X_LO, rd);
        chk("rd_x_lo", rd, 8'(5 + AI));
        reg_read(REG_Y, rd);
        chk("rd_y", rd, 8'd2);
        repeat (3) cycle();
        chk("rd_hold", bus.reg_dout, 8'd2);

        // Fill to full, fifth write overflows
        set_xy(10, 0);
        set_addr(REG_PIXEL);
        for (int i = 0; i < 5; i++) begin
            pix(8'(8'h10 + i));
            if (i == 2) chk("ovf_busy_3", bus.busy, 1'b0);
            if (i == 3) chk("ovf_busy_4", bus.busy, 1'b1);
        end
        chk("ovf_busy_5", bus.busy, 1'b1);
        chk("ovf_head", bus.fb_addr, 17'd10);
        reg_read(REG_STATUS, rd);
        chk("ovf_status1", rd, 8'h44);
        reg_read(REG_STATUS, rd);
        chk("ovf_status2", rd, 8'h04);
        reg_read(REG_X_LO, rd);
        chk("ovf_x_kept", rd, 8'(10 + 4 * AI));
        drain("ovf");

        // Full FIFO with a pop in the same cycle still rejects the push
        set_xy(20, 1);
        set_addr(REG_PIXEL);
        for (int i = 0; i < 4; i++) pix(8'(8'h30 + i));
        bus.fb_ready = 1'b1;
        pix(8'hAA);
        bus.fb_ready = 1'b0;
        reg_read(REG_STATUS, rd);
        chk("sp_status", rd, 8'h43);
        drain("sp");

        // Out-of-range x
        set_xy(400, 0);
        set_addr(REG_PIXEL);
        pix(8'h55);
        chk("rng_fb_we", bus.fb_we, 1'b0);
        reg_read(REG_STATUS, rd);
        chk("rng_status", rd, 8'h80);
        reg_read(REG_X_LO, rd);
        chk("rng_x_lo", rd, 8'h90);
        reg_read(REG_X_HI, rd);
        chk("rng_x_hi", rd, 8'h01);
        reg_read(REG_STATUS, rd);
        chk("rng_status_clr", rd, 8'h00);
        // Out-of-range y
        set_xy(0, 240);
        set_addr(REG_PIXEL);
        pix(8'h66);
        chk("rngy_fb_we", bus.fb_we, 1'b0);
        reg_read(REG_STATUS, rd);
        chk("rngy_status", rd, 8'h80);

        // Last pixel of the frame, then one more
        set_xy(319, 239);
        set_addr(REG_PIXEL);
        pix(8'h01);
        chk("wrap_first", bus.fb_addr, 17'd76799);
        pix(8'h02);
        reg_read(REG_X_LO, rd);
        chk("wrap_x_lo", rd, (AI == 1) ? 8'h01 : 8'h3F);
        bus.fb_ready = 1'b1;
        cycle();
        bus.fb_ready = 1'b0;
        chk("wrap_second", bus.fb_addr, (AI == 1) ? 17'd0 : 17'd76799);
        drain("wrap");

        // Streaming with fb_ready high: push and pop together hold count at 1
        set_xy(7, 3);
        set_addr(REG_PIXEL);
        bus.fb_ready = 1'b1;
        for (int i = 0; i < 6; i++) pix(8'(8'h70 + i));
        bus.fb_ready = 1'b0;
        chk("stream_busy", bus.busy, 1'b0);
        reg_read(REG_STATUS, rd);
        chk("stream_status", rd, 8'h01);
        drain("stream");

        // Address and data strobes together: address wins
        set_xy(33, 4);
        set_addr(REG_X_LO);
        bus.reg_addr_wr = 1'b1;
        bus.reg_data_wr = 1'b1;
        bus.reg_din     = {5'b0, REG_Y};
        cycle();
        bus.reg_addr_wr = 1'b0;
        bus.reg_data_wr = 1'b0;
        wr_data(8'h07);
        reg_read(REG_X_LO, rd);
        chk("coinc_x", rd, 8'd33);
        reg_read(REG_Y, rd);
        chk("coinc_y", rd, 8'h07);
        my = 7;
        // Reserved registers
        reg_write(3'd5, 8'hFF);
        reg_read(3'd5, rd);
        chk("rsv5", rd, 8'h00);
        reg_read(3'd7, rd);
        chk("rsv7", rd, 8'h00);
        reg_read(REG_X_LO, rd);
        chk("rsv_x_kept", rd, 8'd33);

        // Reset with queued pixels
        set_xy(1, 1);
        set_addr(REG_PIXEL);
        for (int i = 0; i < 3; i++) pix(8'(8'hC0 + i));
        chk("mrst_fb_we_pre", bus.fb_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_fb_we", bus.fb_we, 1'b0);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_reg_dout", bus.reg_dout, 8'h00);
        sbq.delete();
        mx = 0;
        my = 0;
        cycle();
        reset = 1'b0;
        cycle();
        chk("mrst_fb_we_post", bus.fb_we, 1'b0);
        reg_read(REG_STATUS, rd);
        chk("mrst_status", rd, 8'h00);
        reg_read(REG_X_LO, rd);
        chk("mrst_x_lo", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
